sdram_read_frame: RTL and testbench

Reads one stored RGB frame back from DDR over an Avalon-MM burst-read master and outputs it as a pixel stream (r/g/b + valid/ready). It is the consumer of the frame buffers filled by the DDR frame writer, and it uses the same buffer-address registers and packing: each 64-bit word holds two pixels as {8'd0,b,g,r}, with the older pixel in [63:32]. Read requests are credit-based, so returning read data can never overflow the local FIFO.

---
 rtl/sdram_read_frame_if.sv | 44 ++++
 rtl/sdram_read_frame.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_read_frame.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_read_frame_if.sv
// ---------------------------------------------------------------------------
// sdram_read_frame_if
// Bus bundle for the DDR frame reader: the Avalon-MM burst-read master port
// and the outgoing RGB pixel stream.
//
//   avl_address       word address of the burst start     (master -> slave)
//   avl_read          read request                        (master -> slave)
//   avl_burstcount    words in the current burst          (master -> slave)
//   avl_waitrequest   slave stall                         (slave  -> master)
//   avl_readdata      returned 64-bit word                (slave  -> master)
//   avl_readdatavalid returned word valid, never stalled  (slave  -> master)
//   r_out/g_out/b_out pixel components                    (master -> slave)
//   pix_valid         pixel available                     (master -> slave)
//   pix_ready         downstream accepts the pixel        (slave  -> master)
// ---------------------------------------------------------------------------
interface sdram_read_frame_if #(
    parameter int ADDR_W = 29
);
    logic [ADDR_W-1:0] avl_address;
    logic              avl_read;
    logic [7:0]        avl_burstcount;
    logic              avl_waitrequest;
    logic [63:0]       avl_readdata;
    logic              avl_readdatavalid;
    logic [7:0]        r_out;
    logic [7:0]        g_out;
    logic [7:0]        b_out;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output avl_address, avl_read, avl_burstcount,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid,
        output r_out, g_out, b_out, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  avl_address, avl_read, avl_burstcount,
        output avl_waitrequest, avl_readdata, avl_readdatavalid,
        input  r_out, g_out, b_out, pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/sdram_read_frame.sv
// ---------------------------------------------------------------------------
// sdram_read_frame
// Reads one stored RGB frame back from DDR with Avalon-MM burst reads and
// emits it as a registered pixel stream. Each 64-bit word carries two pixels
// packed as {8'd0,b,g,r}; the older pixel sits in [63:32]. Bursts are only
// requested when the local FIFO has room for every word already in flight
// plus the new burst, so returning data can never overflow it.
//
//   clk_100, reset_n        clock, asynchronous active-low reset
//   start_frame, buf_sel    frame start pulse and buffer select (0: buf 1)
//   reg_addr_buf_1/2        frame buffer base word addresses
//   io (master)             Avalon burst-read port and pixel stream
//   busy                    frame in progress
//   frame_done              one-cycle pulse after the last pixel is accepted
//   overflow_err            sticky: read data arrived with the FIFO full
// ---------------------------------------------------------------------------
module sdram_read_frame #(
    parameter int BURST_LEN   = 32,
    parameter int FRAME_WORDS = 1036800,
    parameter int FIFO_DEPTH  = 256,
    parameter int ADDR_W      = 29
) (
    input  logic               clk_100,
    input  logic               reset_n,
    input  logic               start_frame,
    input  logic               buf_sel,
    input  logic [31:0]        reg_addr_buf_1,
    input  logic [31:0]        reg_addr_buf_2,
    sdram_read_frame_if.master io,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NEED_W = CNT_W + 2;
    localparam int WL_RAW = $clog2(FRAME_WORDS + 1);
    // At least 9 bits so BURST_LEN (up to 128) always fits for the min().
    localparam int WL_W   = (WL_RAW > 9) ? WL_RAW : 9;

    typedef enum logic [1:0] {IDLE, CHECK, REQ, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur_addr;
    logic [WL_W-1:0]     words_left;
    logic [CNT_W-1:0]    outstanding;
    logic [ADDR_W-1:0]   avl_address_q;
    logic [7:0]          avl_burstcount_q;
    logic [7:0]          blen;
    logic [NEED_W-1:0]   need;
    logic                credit_ok;
    logic                req_issue;
    logic                req_accept;
    logic                done_hit;
    logic [CNT_W-1:0]    out_inc;
    logic [CNT_W-1:0]    out_dec;

    logic [63:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full, fifo_empty, fifo_wr, fifo_pop;
    logic [63:0]         head_p0;

    logic                phase;
    logic                pix_load;
    logic [7:0]          r_p1, g_p1, b_p1;
    logic                vld_p1;
    logic                unused_bits;

    assign unused_bits = ^{reg_addr_buf_1[31:ADDR_W], reg_addr_buf_2[31:ADDR_W],
                           head_p0[63:56], head_p0[31:24]};

    // Burst length and credit check: the FIFO must hold what it has, what is
    // still in flight, and the whole burst about to be requested.
    always_comb begin
        if (words_left < WL_W'(BURST_LEN)) blen = words_left[7:0];
        else                                blen = 8'(BURST_LEN);
    end

    assign need      = NEED_W'(fifo_count) + NEED_W'(outstanding) + NEED_W'(blen);
    assign credit_ok = (need <= NEED_W'(FIFO_DEPTH));

    always_comb begin
        state_nxt  = state;
        req_issue  = 1'b0;
        req_accept = 1'b0;
        done_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (start_frame) state_nxt = CHECK;
            end
            CHECK: begin
                if (credit_ok) begin
                    req_issue = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!io.avl_waitrequest) begin
                    req_accept = 1'b1;
                    state_nxt  = (words_left == WL_W'(avl_burstcount_q)) ? DRAIN : CHECK;
                end
            end
            DRAIN: begin
                // With nothing in flight and the FIFO empty, the pixel in the
                // output register is the last one of the frame.
                if (outstanding == '0 && fifo_empty && vld_p1 && io.pix_ready) begin
                    done_hit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_inc = req_accept ? CNT_W'(avl_burstcount_q) : '0;
    assign out_dec = io.avl_readdatavalid ? CNT_W'(1) : '0;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cur_addr         <= '0;
            words_left       <= '0;
            outstanding      <= '0;
            avl_address_q    <= '0;
            avl_burstcount_q <= '0;
            frame_done       <= 1'b0;
            overflow_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_done  <= done_hit;
            outstanding <= outstanding + out_inc - out_dec;
            if (io.avl_readdatavalid && fifo_full) overflow_err <= 1'b1;
            if (state == IDLE && start_frame) begin
                cur_addr   <= buf_sel ? reg_addr_buf_2[ADDR_W-1:0] : reg_addr_buf_1[ADDR_W-1:0];
                words_left <= WL_W'(FRAME_WORDS);
            end
            if (req_issue) begin
                avl_address_q    <= cur_addr;
                avl_burstcount_q <= blen;
            end
            if (req_accept) begin
                // Address wraps modulo 2^ADDR_W by plain truncation.
                cur_addr   <= cur_addr + ADDR_W'(BURST_LEN);
                words_left <= words_left - WL_W'(avl_burstcount_q);
            end
        end
    end

    assign io.avl_read       = (state == REQ);
    assign io.avl_address    = avl_address_q;
    assign io.avl_burstcount = avl_burstcount_q;
    assign busy              = (state != IDLE);

    // ---- stage p0: show-ahead read-data FIFO ----
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_wr    = io.avl_readdatavalid && !fifo_full;
    assign head_p0    = fifo_mem[rd_ptr];
    assign pix_load   = (!vld_p1 || io.pix_ready) && !fifo_empty;
    // The word leaves the FIFO only once its second (newer) pixel is taken.
    assign fifo_pop   = pix_load && phase;

    always_ff @(posedge clk_100) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= io.avl_readdata;
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
        end
    end

    // ---- stage p1: unpacker / registered pixel output ----
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= 1'b0;
            vld_p1 <= 1'b0;
            r_p1   <= '0;
            g_p1   <= '0;
            b_p1   <= '0;
        end else begin
            if (pix_load) begin
                vld_p1 <= 1'b1;
                phase  <= ~phase;
                if (!phase) begin
                    r_p1 <= head_p0[39:32];
                    g_p1 <= head_p0[47:40];
                    b_p1 <= head_p0[55:48];
                end else begin
                    r_p1 <= head_p0[7:0];
                    g_p1 <= head_p0[15:8];
                    b_p1 <= head_p0[23:16];
                end
            end else if (io.pix_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign io.r_out     = r_p1;
    assign io.g_out     = g_p1;
    assign io.b_out     = b_p1;
    assign io.pix_valid = vld_p1;

endmodule

// File: tb/tb_sdram_read_frame.sv
// ---------------------------------------------------------------------------
// tb_sdram_read_frame
// Scoreboard bench for sdram_read_frame. Starting a frame pushes the expected
// bursts and pixels (computed from the base address and frame length) into
// queues; an Avalon slave model and a pixel monitor pop and compare.
// ---------------------------------------------------------------------------
module tb_sdram_read_frame;

    localparam int BL = 32;
    localparam int FW = 72;
    localparam int FD = 64;
    localparam int AW = 29;

    logic        clk_100 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_frame = 1'b0;
    logic        buf_sel = 1'b0;
    logic [31:0] reg_addr_buf_1 = '0;
    logic [31:0] reg_addr_buf_2 = '0;
    logic        busy, frame_done, overflow_err;

    sdram_read_frame_if #(.ADDR_W(AW)) io ();

    sdram_read_frame #(
        .BURST_LEN(BL), .FRAME_WORDS(FW), .FIFO_DEPTH(FD), .ADDR_W(AW)
    ) dut (
        .clk_100(clk_100), .reset_n(reset_n), .start_frame(start_frame),
        .buf_sel(buf_sel), .reg_addr_buf_1(reg_addr_buf_1),
        .reg_addr_buf_2(reg_addr_buf_2), .io(io), .busy(busy),
        .frame_done(frame_done), .overflow_err(overflow_err)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // stimulus knobs written by the main sequence
    int          ready_mode = 1;    // 0: never ready, 1: always, 2: random 50%
    int          wait_mode = 0;     // 0: none, 1: 5-cycle stall per request, 2: random
    int          lat_max = 1;       // beat spacing drawn from 0..lat_max-1
    logic [31:0] cur_salt = '0;
    logic        in_frame = 1'b0;

    // counters owned by the monitors; main keeps base snapshots
    int done_cnt = 0, rx_cnt = 0, acc_cnt = 0, words_req = 0, busy_viol = 0;
    int done_base = 0, rx_base = 0, acc_base = 0, wreq_base = 0, viol_base = 0;
    int last_xfer_cyc = -10;
    logic [23:0] rx_first [2];

    // scoreboard queues
    logic [23:0]   exp_pix [$];
    logic [AW-1:0] exp_baddr [$];
    int            exp_bcnt [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: arbitrary but reproducible per address and frame salt.
    function automatic logic [63:0] mem_word(input logic [AW-1:0] a, input logic [31:0] salt);
        logic [31:0] x;
        if (salt == 32'd0 && a == AW'(32'h100)) return 64'h00332211_00665544;
        x = {3'b000, a} ^ salt;
        return {(x * 32'h9E3779B1) ^ 32'h5BD1E995, (x + 32'h01234567) * 32'h85EBCA6B};
    endfunction

    // Reference model: bursts of BL from the base (last one short), words
    // read in address order, older pixel from the upper half first.
    task automatic model_frame(input logic [AW-1:0] base, input logic [31:0] salt);
        logic [63:0] w;
        for (int i = 0; i < FW; i += BL) begin
            exp_baddr.push_back(AW'(base + i));
            exp_bcnt.push_back((FW - i < BL) ? FW - i : BL);
        end
        for (int i = 0; i < FW; i++) begin
            w = mem_word(AW'(base + i), salt);
            exp_pix.push_back({w[39:32], w[47:40], w[55:48]});
            exp_pix.push_back({w[7:0], w[15:8], w[23:16]});
        end
    endtask

    // Avalon slave: waitrequest, burst checking, in-order data return.
    initial begin
        logic [63:0]   ret_q [$];
        int            stall;
        int            gap;
        logic          prev_wait;
        logic          w;
        logic [AW-1:0] held_a;
        logic [7:0]    held_n;
        stall = 0; gap = 0; prev_wait = 1'b0; held_a = '0; held_n = '0;
        io.avl_waitrequest   = 1'b0;
        io.avl_readdatavalid = 1'b0;
        io.avl_readdata      = '0;
        forever begin
            @(negedge clk_100);
            if (!reset_n) begin
                ret_q.delete();
                stall = 0; gap = 0; prev_wait = 1'b0;
                io.avl_waitrequest   = 1'b0;
                io.avl_readdatavalid = 1'b0;
                continue;
            end
            if (ret_q.size() > 0 && gap == 0) begin
                io.avl_readdatavalid = 1'b1;
                io.avl_readdata      = ret_q.pop_front();
                gap = $urandom_range(0, lat_max - 1);
            end else begin
                io.avl_readdatavalid = 1'b0;
                io.avl_readdata      = {$urandom, $urandom};
                if (gap > 0) gap--;
            end
            if (prev_wait)
                chk("req_stable", {io.avl_read, io.avl_burstcount, 3'b000, io.avl_address},
                    {1'b1, held_n, 3'b000, held_a});
            if (io.avl_read) begin
                if (wait_mode == 1)      w = (stall < 5);
                else if (wait_mode == 2) w = ($urandom_range(0, 2) == 0);
                else                     w = 1'b0;
                io.avl_waitrequest = w;
                if (w) begin
                    stall++;
                    prev_wait = 1'b1;
                    held_a = io.avl_address;
                    held_n = io.avl_burstcount;
                end else begin
                    stall = 0;
                    prev_wait = 1'b0;
                    acc_cnt++;
                    words_req += int'(io.avl_burstcount);
                    if (exp_baddr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL burst_unexpected: got addr %0h count %0d expected none",
                                 io.avl_address, io.avl_burstcount);
                    end else begin
                        chk("burst_addr", io.avl_address, exp_baddr.pop_front());
                        chk("burst_count", io.avl_burstcount, exp_bcnt.pop_front());
                    end
                    for (int k = 0; k < int'(io.avl_burstcount); k++)
                        ret_q.push_back(mem_word(AW'(io.avl_address + k), cur_salt));
                end
            end else begin
                io.avl_waitrequest = (wait_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_wait = 1'b0;
            end
        end
    end

    // Pixel sink and monitor.
    initial begin
        logic        prev_hold;
        logic [23:0] held_pix;
        logic [23:0] rgb;
        prev_hold = 1'b0; held_pix = '0;
        io.pix_ready = 1'b0;
        forever begin
            @(negedge clk_100);
            case (ready_mode)
                0:       io.pix_ready = 1'b0;
                1:       io.pix_ready = 1'b1;
                default: io.pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (!reset_n) begin
                prev_hold = 1'b0;
                continue;
            end
            rgb = {io.r_out, io.g_out, io.b_out};
            if (prev_hold) chk("pix_hold", {io.pix_valid, rgb}, {1'b1, held_pix});
            if (frame_done) begin
                done_cnt++;
                chk("done_timing", cyc, last_xfer_cyc);
                chk("busy_after_done", busy, 1'b0);
            end else if (in_frame && done_cnt == done_base && !busy) begin
                busy_viol++;
            end
            if (io.pix_valid && io.pix_ready) begin
                if (rx_cnt - rx_base < 2) rx_first[rx_cnt - rx_base] = rgb;
                rx_cnt++;
                last_xfer_cyc = cyc + 1;
                if (exp_pix.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pixel_unexpected: got %0h expected none", rgb);
                end else begin
                    chk("pixel", rgb, exp_pix.pop_front());
                end
            end
            prev_hold = io.pix_valid && !io.pix_ready;
            held_pix  = rgb;
        end
    end

    task automatic start(input logic sel, input logic [31:0] b1, input logic [31:0] b2,
                         input logic [31:0] salt);
        @(posedge clk_100); #1;
        reg_addr_buf_1 = b1;
        reg_addr_buf_2 = b2;
        buf_sel   = sel;
        cur_salt  = salt;
        rx_base   = rx_cnt;
        acc_base  = acc_cnt;
        wreq_base = words_req;
        viol_base = busy_viol;
        done_base = done_cnt;
        model_frame(sel ? b2[AW-1:0] : b1[AW-1:0], salt);
        start_frame = 1'b1;
        @(posedge clk_100); #1;
        start_frame = 1'b0;
        in_frame = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 4000) begin
            @(posedge clk_100);
            n++;
        end
        repeat (5) @(posedge clk_100);
        #1;
        in_frame = 1'b0;
        chk({name, "_done_pulses"}, done_cnt - done_base, 1);
        chk({name, "_pixels"}, rx_cnt - rx_base, 2 * FW);
        chk({name, "_pix_left"}, exp_pix.size(), 0);
        chk({name, "_bursts_left"}, exp_baddr.size(), 0);
        chk({name, "_busy_throughout"}, busy_viol - viol_base, 0);
        chk({name, "_busy_idle"}, busy, 1'b0);
        chk({name, "_overflow"}, overflow_err, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_avl_read"}, io.avl_read, 1'b0);
        chk({name, "_avl_address"}, io.avl_address, '0);
        chk({name, "_avl_burstcount"}, io.avl_burstcount, '0);
        chk({name, "_pix_valid"}, io.pix_valid, 1'b0);
        chk({name, "_rgb"}, {io.r_out, io.g_out, io.b_out}, '0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_frame_done"}, frame_done, 1'b0);
        chk({name, "_overflow"}, overflow_err, 1'b0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk_100);
        #1;
        chk_reset_outputs("rst");
        reset_n = 1'b1;

        // A: buffer 1 at 0x100, zero-wait slave, always ready
        ready_mode = 1; wait_mode = 0; lat_max = 1;
        start(1'b0, 32'h100, 32'h0, 32'd0);
        wait_done("A");
        chk("A_first_pixel", rx_first[0], 24'h112233);
        chk("A_second_pixel", rx_first[1], 24'h445566);
        chk("A_acceptances", acc_cnt - acc_base, 3);

        // B: buffer 2 near the top of the address space, wraps to 0x10
        lat_max = 10;
        start(1'b1, 32'h200, 32'hFFFF_FFF0, $urandom | 32'd1);
        wait_done("B");

        // C: downstream stalled, credits must stop requests at FIFO_DEPTH
        ready_mode = 0; lat_max = 3;
        start(1'b0, 32'h4000, 32'h0, $urandom | 32'd1);
        repeat (400) @(posedge clk_100);
        #1;
        chk("C_words_requested", words_req - wreq_base, FD);
        chk("C_acceptances", acc_cnt - acc_base, 2);
        chk("C_no_overflow", overflow_err, 1'b0);
        chk("C_pix_valid_held", io.pix_valid, 1'b1);
        ready_mode = 1;
        wait_done("C");

        // D: five-cycle waitrequest on every request
        wait_mode = 1; lat_max = 2;
        start(1'b1, 32'h0, 32'h0ABC_0000, $urandom | 32'd1);
        wait_done("D");
        chk("D_acceptances", acc_cnt - acc_base, 3);

        // E: random ready, random latency and waits, ignored second start
        wait_mode = 2; ready_mode = 2; lat_max = 10;
        start(1'b0, 32'h0123_4560, 32'h0765_4320, $urandom | 32'd1);
        repeat (20) @(posedge clk_100);
        #1;
        buf_sel = 1'b1;
        start_frame = 1'b1;
        @(posedge clk_100); #1;
        start_frame = 1'b0;
        wait_done("E");

        // F: reset during the second burst, then a clean frame
        wait_mode = 0; ready_mode = 1; lat_max = 4;
        start(1'b0, 32'h0002_0000, 32'h0, $urandom | 32'd1);
        n = 0;
        while (acc_cnt - acc_base < 2 && n < 500) begin
            @(posedge clk_100);
            n++;
        end
        chk("F_second_burst_seen", acc_cnt - acc_base, 2);
        repeat (3) @(posedge clk_100);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("F_rst");
        exp_pix.delete();
        exp_baddr.delete();
        exp_bcnt.delete();
        in_frame = 1'b0;
        repeat (3) @(posedge clk_100);
        #1;
        reset_n = 1'b1;

        wait_mode = 2; ready_mode = 2; lat_max = 5;
        start(1'b1, 32'h0, 32'h0003_0008, $urandom | 32'd1);
        wait_done("G");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
